debug_unit_tx: RTL

DEBUG_UNIT_TX -- requirements
Module: debug_unit_tx

---
 rtl/debug_unit_tx.sv | 115 +++++++++++
 1 files changed

// File: rtl/debug_unit_tx.sv
// ==========================================================================
// debug_unit_tx : snapshots CPU state on halt/dump request and streams it
// as a byte frame. Optional cycle counter: DEBUG_UNIT_CYCLE_COUNT_EN. Rev 1.0
// ==========================================================================
`default_nettype none

module debug_unit_tx #(
   parameter logic [7:0] HEADER = 8'hA5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1023:0] du_reg,
   input  logic [255:0]  du_mem,
   input  logic [63:0]   du_if_id,
   input  logic [125:0]  du_id_ex,
   input  logic          du_halt,
   input  logic          dump_req,
   input  logic          tx_ready,
   output logic [7:0]    tx_data,
   output logic          tx_valid,
   output logic          busy,
   output logic          done
);

`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
   localparam int SNAP_W = 1504;
`else
   localparam int SNAP_W = 1472;
`endif
   localparam int         FRAME_LEN = SNAP_W / 8 + 1;
   localparam logic [7:0] LAST_IDX  = 8'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state, state_next;
   logic [7:0]          idx;
   logic [SNAP_W-1:0]   snap;
   logic [SNAP_W-1:0]   snap_in;
   logic                halt_q;
   logic                trigger;
   logic                accept;

`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
   logic [31:0] cycle_cnt;

   // Counts running cycles; freezes while halted and saturates at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cycle_cnt <= 32'd0;
      else if (!du_halt && cycle_cnt != 32'hFFFF_FFFF)
         cycle_cnt <= cycle_cnt + 32'd1;
   end

   assign snap_in = {cycle_cnt, du_mem, du_reg, 2'b00, du_id_ex, du_if_id};
`else
   assign snap_in = {du_mem, du_reg, 2'b00, du_id_ex, du_if_id};
`endif

   assign accept   = (state == SEND) && tx_ready;
   assign tx_valid = (state == SEND);
   assign busy     = (state == SEND) || (state == DONE);
   assign done     = (state == DONE);
   // Snapshot is consumed from the bottom, so the current byte is always snap[7:0].
   assign tx_data  = (state != SEND) ? 8'h00 : ((idx == 8'd0) ? HEADER : snap[7:0]);

   always_comb begin
      state_next = state;
      trigger    = 1'b0;
      case (state)
         IDLE: begin
            trigger = (du_halt && !halt_q) || dump_req;
            if (trigger)
               state_next = SEND;
         end
         SEND: begin
            if (accept && idx == LAST_IDX)
               state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx    <= 8'd0;
         snap   <= '0;
         halt_q <= 1'b0;
      end else begin
         halt_q <= du_halt;
         if (trigger) begin
            snap <= snap_in;
            idx  <= 8'd0;
         end else if (accept) begin
            idx <= idx + 8'd1;
            if (idx != 8'd0)
               snap <= snap >> 8;
         end
      end
   end

endmodule

`default_nettype wire
